// File: rtl/cam_pixel_packer.sv
// ============================================================================
// Module   : cam_pixel_packer
// Purpose  : Camera byte capture, RGB565 pair packing into 32-bit words and a
//            small elastic FIFO toward the frame buffer write port.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cam_pixel_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [7:0]            cam_data,
    input  logic                  wr_rdy,
    output logic                  wr_en_in,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  ovf
);

    localparam int LINE_W = $clog2(V_ACTIVE + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PW     = AW + 1;
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE);

    generate
        if ((DATA_WIDTH != 32) || (H_ACTIVE < 2) || (V_ACTIVE < 1) ||
            (FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_cfg
            $error("cam_pixel_packer: unsupported parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    vsync_q;
    logic                    href_q;
    logic [LINE_W-1:0]       line_cnt_q;
    logic [1:0]              byte_cnt_q;
    logic [23:0]             pack_q;
    logic                    frame_done_q;
    logic                    frame_err_q;
    logic                    ovf_q;
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];

    logic                    w_vs_rise;
    logic                    w_vs_fall;
    logic                    w_href_fall;
    logic [LINE_W-1:0]       w_line_next;
    logic                    w_push;
    logic [DATA_WIDTH-1:0]   w_push_word;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push_ok;

    assign w_vs_rise   = vsync & ~vsync_q;
    assign w_vs_fall   = ~vsync & vsync_q;
    assign w_href_fall = ~href & href_q;
    assign w_line_next = line_cnt_q + 1'b1;

    // An aborting vsync rise wins over a coincident final byte.
    assign w_push      = (state_q == ST_ACTIVE) & ~w_vs_rise & href & (byte_cnt_q == 2'd3);
    assign w_push_word = {pack_q, cam_data};

    assign w_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) & (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign w_pop     = ~w_empty & wr_rdy;
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            line_cnt_q   <= '0;
            byte_cnt_q   <= 2'd0;
            pack_q       <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            href_q       <= href;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_vs_rise) begin
                        state_q <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_vs_fall) begin
                        state_q    <= ST_ACTIVE;
                        line_cnt_q <= '0;
                        byte_cnt_q <= 2'd0;
                        pack_q     <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_vs_rise) begin
                        frame_err_q <= 1'b1;
                        byte_cnt_q  <= 2'd0;
                        state_q     <= ST_SYNC;
                    end else if (href) begin
                        case (byte_cnt_q)
                            2'd0:    pack_q[23:16] <= cam_data;
                            2'd1:    pack_q[15:8]  <= cam_data;
                            2'd2:    pack_q[7:0]   <= cam_data;
                            default: pack_q        <= pack_q;
                        endcase
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end else if (w_href_fall) begin
                        // Any partial word left in pack_q is simply abandoned.
                        byte_cnt_q <= 2'd0;
                        line_cnt_q <= w_line_next;
                        if (w_line_next == LINE_LAST) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push & w_full & ~w_pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= w_push_word;
        end
    end

    assign wr_en_in   = w_empty;
    assign wr_data    = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign ovf        = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_pixel_packer.sv
// ============================================================================
// Module   : tb_cam_pixel_packer
// Purpose  : Self-checking bench for cam_pixel_packer (H_ACTIVE=4, V_ACTIVE=2).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cam_pixel_packer;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        href;
    logic [7:0]  cam_data;
    logic        wr_rdy;
    logic        wr_en_in;
    logic [31:0] wr_data;
    logic        frame_done;
    logic        frame_err;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int n_done = 0;
    int n_err  = 0;
    bit rdy_rand = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];

    cam_pixel_packer #(
        .DATA_WIDTH (32),
        .H_ACTIVE   (4),
        .V_ACTIVE   (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .href       (href),
        .cam_data   (cam_data),
        .wr_rdy     (wr_rdy),
        .wr_en_in   (wr_en_in),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every word accepted downstream and every status pulse.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (wr_en_in === 1'b0 && wr_rdy === 1'b1) obs_q.push_back(wr_data);
            if (frame_done === 1'b1) n_done++;
            if (frame_err === 1'b1) n_err++;
        end
    end

    task automatic cyc(input logic v, input logic h, input logic [7:0] d);
        vsync    = v;
        href     = h;
        cam_data = d;
        if (rdy_rand) wr_rdy = (wr_rdy == 1'b0) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
    endtask

    task automatic start_frame();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    // Reference: every complete group of 4 bytes in a line becomes one word,
    // first byte in the most significant position.
    task automatic send_line(input int len, input int gap);
        logic [7:0] b[$];
        for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(0, 255)));
        for (int w = 0; w + 4 <= len; w += 4) exp_q.push_back({b[w], b[w+1], b[w+2], b[w+3]});
        for (int i = 0; i < len; i++) cyc(1'b0, 1'b1, b[i]);
        for (int i = 0; i < gap; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (wr_en_in !== 1'b1) begin bad++; $display("FAIL reset_wr_en_in: got %b want 1", wr_en_in); end
        total++; if (wr_data !== 32'h0) begin bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        wr_rdy = 1'b1;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'(i + 1));
        cyc(1'b0, 1'b0, 8'h00);
        total++; if (wr_en_in !== 1'b1) begin bad++; $display("FAIL idle_href_ignored: got wr_en_in=%b want 1", wr_en_in); end
    endtask

    task automatic test_single_word();
        int d0;
        obs_q.delete();
        d0 = n_done;
        wr_rdy = 1'b1;
        start_frame();
        cyc(1'b0, 1'b1, 8'h12);
        cyc(1'b0, 1'b1, 8'h34);
        cyc(1'b0, 1'b1, 8'h56);
        total++; if (wr_en_in !== 1'b1) begin bad++; $display("FAIL single_early: got wr_en_in=%b want 1", wr_en_in); end
        cyc(1'b0, 1'b1, 8'h78);
        total++; if (wr_en_in !== 1'b0) begin bad++; $display("FAIL single_valid: got wr_en_in=%b want 0", wr_en_in); end
        total++; if (wr_data !== 32'h12345678) begin bad++; $display("FAIL single_data: got %h want 12345678", wr_data); end
        cyc(1'b0, 1'b0, 8'h00);
        total++; if (wr_en_in !== 1'b1) begin bad++; $display("FAIL single_one_cycle: got wr_en_in=%b want 1", wr_en_in); end
        cyc(1'b0, 1'b1, 8'haa);
        cyc(1'b0, 1'b1, 8'hbb);
        cyc(1'b0, 1'b1, 8'hcc);
        cyc(1'b0, 1'b1, 8'hdd);
        cyc(1'b0, 1'b0, 8'h00);
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL single_frame_done: got %b want 1", frame_done); end
        cyc(1'b0, 1'b0, 8'h00);
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL single_done_width: got %b want 0", frame_done); end
        total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", n_done - d0); end
        total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL single_word_count: got %0d want 2", obs_q.size()); end
        else begin
            total++; if (obs_q[1] !== 32'haabbccdd) begin bad++; $display("FAIL single_second_word: got %h want aabbccdd", obs_q[1]); end
        end
    endtask

    task automatic test_full_frame();
        int d0;
        obs_q.delete();
        exp_q.delete();
        d0 = n_done;
        wr_rdy = 1'b1;
        start_frame();
        send_line(8, 2);
        send_line(8, 3);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL frame_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL frame_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (n_done - d0 !== 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", n_done - d0); end
    endtask

    task automatic test_overflow();
        obs_q.delete();
        exp_q.delete();
        wr_rdy = 1'b0;
        start_frame();
        send_line(12, 2);
        send_line(8, 2);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
        total++; if (wr_en_in !== 1'b0) begin bad++; $display("FAIL ovf_wr_en_in: got %b want 0", wr_en_in); end
        for (int i = 0; i < 3; i++) begin
            total++; if (wr_data !== exp_q[0]) begin bad++; $display("FAIL ovf_stall_hold: got %h want %h", wr_data, exp_q[0]); end
            cyc(1'b0, 1'b0, 8'h00);
        end
        wr_rdy = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'h00);
        total++; if (obs_q.size() !== 4) begin bad++; $display("FAIL ovf_drain_count: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        apply_reset();
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared: got %b want 0", ovf); end
    endtask

    task automatic test_abort();
        int d0;
        int e0;
        obs_q.delete();
        exp_q.delete();
        d0 = n_done;
        e0 = n_err;
        wr_rdy = 1'b1;
        start_frame();
        send_line(8, 2);
        cyc(1'b0, 1'b1, 8'h5a);
        cyc(1'b0, 1'b1, 8'ha5);
        cyc(1'b1, 1'b0, 8'h00);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL abort_err: got %b want 1", frame_err); end
        cyc(1'b1, 1'b0, 8'h00);
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL abort_err_width: got %b want 0", frame_err); end
        total++; if (n_done - d0 !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", n_done - d0); end
        cyc(1'b0, 1'b0, 8'h00);
        send_line(8, 2);
        send_line(8, 3);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL abort_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (n_done - d0 !== 1 || n_err - e0 !== 1) begin
            bad++; $display("FAIL abort_pulses: got done=%0d err=%0d want 1 1", n_done - d0, n_err - e0);
        end
    endtask

    task automatic test_odd_line();
        obs_q.delete();
        exp_q.delete();
        wr_rdy = 1'b1;
        start_frame();
        send_line(6, 2);
        send_line(4, 3);
        total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL odd_count: got %0d want 2", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL odd_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_line();
        wr_rdy = 1'b0;
        start_frame();
        send_line(8, 1);
        cyc(1'b0, 1'b1, 8'h11);
        cyc(1'b0, 1'b1, 8'h22);
        total++; if (wr_en_in !== 1'b0) begin bad++; $display("FAIL rst_mid_queued: got wr_en_in=%b want 0", wr_en_in); end
        reset = 1'b1;
        cyc(1'b0, 1'b1, 8'h33);
        total++; if (wr_en_in !== 1'b1) begin bad++; $display("FAIL rst_mid_flush: got wr_en_in=%b want 1", wr_en_in); end
        total++; if (wr_data !== 32'h0) begin bad++; $display("FAIL rst_mid_data: got %h want 0", wr_data); end
        reset = 1'b0;
        wr_rdy = 1'b1;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'(8'hc0 + i));
            total++; if (wr_en_in !== 1'b1) begin bad++; $display("FAIL rst_mid_ignored: got wr_en_in=%b want 1", wr_en_in); end
        end
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL rst_mid_no_output: got %0d want 0", obs_q.size()); end
        start_frame();
        send_line(8, 2);
        send_line(8, 3);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL rst_mid_recover_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rst_mid_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_frames();
        int d0;
        obs_q.delete();
        exp_q.delete();
        d0 = n_done;
        wr_rdy = 1'b1;
        rdy_rand = 1'b1;
        for (int f = 0; f < 6; f++) begin
            start_frame();
            for (int l = 0; l < 2; l++) send_line($urandom_range(1, 20), $urandom_range(1, 3));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) cyc(1'b0, 1'b0, 8'h00);
        end
        rdy_rand = 1'b0;
        wr_rdy = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'h00);
        total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (n_done - d0 !== 6) begin bad++; $display("FAIL rand_done_count: got %0d want 6", n_done - d0); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rand_no_ovf: got %b want 0", ovf); end
    endtask

    initial begin
        reset    = 1'b1;
        vsync    = 1'b0;
        href     = 1'b0;
        cam_data = 8'h00;
        wr_rdy   = 1'b0;
        test_reset();
        test_single_word();
        test_full_frame();
        test_overflow();
        test_abort();
        test_odd_line();
        test_reset_mid_line();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
